// File: rtl/cpu_run_ctrl.sv
// Program-load and run sequencer for the 16-bit cpu: streams words into imem with the cpu
// held in reset, then releases it and gates cpu_en until halt or the cycle limit.
`timescale 1ns/1ps
module cpu_run_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int CYC_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  cpu_en,
    input  logic                  cpu_halted,
    input  logic                  run_start,
    input  logic                  step_mode,
    input  logic                  step_req,
    input  logic [CYC_WIDTH-1:0]  cycle_limit,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CYC_WIDTH-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CPURST,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]  ONE_A = 1;
    localparam logic [CYC_WIDTH-1:0] ONE_C = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  step_q, step_d;
    logic [CYC_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    // The word index is one bit wider than the address so a full-memory load can be counted.
    assign imem_addr   = idx_q[ADDR_WIDTH-1:0];
    assign imem_wdata  = in_data;
    assign cycle_count = cnt_q;
    assign timeout     = timeout_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        cpu_rst_n = 1'b0;
        cpu_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // After a run the cpu stays out of reset so its state can be inspected.
                cpu_rst_n = (state_q == S_DONE);
                done      = (state_q == S_DONE);
                if (load_start && (load_len != '0)) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    len_d   = load_len;
                end else if (run_start) begin
                    state_d = S_CPURST;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                imem_we  = in_valid;
                if (in_valid) begin
                    if (idx_q == len_q - ONE_A) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ONE_A;
                    end
                end
            end
            S_CPURST: begin
                busy      = 1'b1;
                cnt_d     = '0;
                timeout_d = 1'b0;
                step_d    = step_mode;
                state_d   = S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                cpu_rst_n = 1'b1;
                if (cpu_halted) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if ((cycle_limit != '0) && (cnt_q == cycle_limit)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    cpu_en = step_q ? step_req : 1'b1;
                    if (cpu_en && (cnt_q != '1)) begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            step_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
